// File: rtl/div_datapath_if.sv
// Handshake and operand/result bus for div_datapath.
// master: the requester driving Run/W_ctrl/operands; slave: the divider.
interface div_datapath_if;
  logic        Run;
  logic        W_ctrl;
  logic [31:0] Dividend;
  logic [31:0] Divisor;
  logic [31:0] Quotient;
  logic [31:0] Remainder;
  logic        Done;
  logic        DivZero;

  modport master (
    output Run, W_ctrl, Dividend, Divisor,
    input  Quotient, Remainder, Done, DivZero
  );

  modport slave (
    input  Run, W_ctrl, Dividend, Divisor,
    output Quotient, Remainder, Done, DivZero
  );
endinterface

// File: rtl/div_datapath.sv
// div_datapath: 32-bit restoring divider, one quotient bit per enabled edge.
// Load edge + 32 step edges = 33 edges to Done; divide by zero completes on
// the edge after load. W_ctrl=0 stalls; Run=0 aborts/returns to IDLE.
// Optional feature: define DIV_SIGNED_EN for two's-complement operands
// (magnitudes at load, sign fix-up applied combinationally at the output write).
module div_datapath (
  input  logic          clk,
  input  logic          Reset,
  div_datapath_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t      state, state_next;

  logic [31:0] rem;       // partial remainder (bit 32 of the working value is always 0 after a step)
  logic [31:0] sreg;      // dividend shifts out of the top, quotient bits shift in at the bottom
  logic [31:0] dsr;       // captured divisor (magnitude in signed mode)
  logic [5:0]  cnt;
  logic        dz_pend;   // divide-by-zero result still to be written

  logic        load, step, finish, dz_write;

  logic [32:0] rem_sh;
  logic        ge;
  logic [32:0] rem_next;
  logic [31:0] q_raw;
  logic [31:0] q_out, r_out;
  logic [31:0] dvd_load, dsr_load;

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;

  // Magnitudes at load; a zero divisor keeps the raw dividend so it can be returned unchanged.
  always_comb begin
    dsr_load = bus.Divisor[31]  ? -bus.Divisor  : bus.Divisor;
    dvd_load = bus.Dividend[31] ? -bus.Dividend : bus.Dividend;
    if (bus.Divisor == '0) dvd_load = bus.Dividend;
  end

  // Sign fix-up at the output write: quotient negative if signs differ, remainder follows dividend.
  always_comb begin
    q_out = neg_q ? -q_raw : q_raw;
    r_out = neg_r ? -rem_next[31:0] : rem_next[31:0];
  end
`else
  // Unsigned operands pass straight through.
  always_comb begin
    dsr_load = bus.Divisor;
    dvd_load = bus.Dividend;
    q_out    = q_raw;
    r_out    = rem_next[31:0];
  end
`endif

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  always_comb begin
    rem_sh   = {rem, sreg[31]};
    ge       = (rem_sh >= {1'b0, dsr});
    rem_next = ge ? (rem_sh - {1'b0, dsr}) : rem_sh;
    q_raw    = {sreg[30:0], ge};
  end

  // State register.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and datapath strobes; Run=0 wins over a stall so aborts are never blocked.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    dz_write   = 1'b0;
    if (!bus.Run) begin
      state_next = IDLE;
    end else if (bus.W_ctrl) begin
      case (state)
        IDLE: begin
          load       = 1'b1;
          state_next = (bus.Divisor == '0) ? DONE : ITER;
        end
        ITER: begin
          step = 1'b1;
          if (cnt == 6'd31) begin
            finish     = 1'b1;
            state_next = DONE;
          end
        end
        DONE: begin
          dz_write = dz_pend;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Operand/iteration registers and result outputs.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      rem           <= '0;
      sreg          <= '0;
      dsr           <= '0;
      cnt           <= '0;
      dz_pend       <= 1'b0;
      bus.Quotient  <= '0;
      bus.Remainder <= '0;
      bus.Done      <= 1'b0;
      bus.DivZero   <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
`endif
    end else begin
      if (!bus.Run) begin
        bus.Done <= 1'b0;
        dz_pend  <= 1'b0;
      end
      if (load) begin
        rem         <= '0;
        sreg        <= dvd_load;
        dsr         <= dsr_load;
        cnt         <= '0;
        dz_pend     <= (bus.Divisor == '0);
        bus.Done    <= 1'b0;
        bus.DivZero <= 1'b0;
`ifdef DIV_SIGNED_EN
        neg_q       <= bus.Dividend[31] ^ bus.Divisor[31];
        neg_r       <= bus.Dividend[31];
`endif
      end
      if (step) begin
        rem  <= rem_next[31:0];
        sreg <= q_raw;
        cnt  <= cnt + 6'd1;
        if (finish) begin
          bus.Quotient  <= q_out;
          bus.Remainder <= r_out;
          bus.Done      <= 1'b1;
        end
      end
      if (dz_write) begin
        bus.Quotient  <= '1;
        bus.Remainder <= sreg;
        bus.DivZero   <= 1'b1;
        bus.Done      <= 1'b1;
        dz_pend       <= 1'b0;
      end
    end
  end

endmodule

// File: doc/div_datapath.md
DIV_DATAPATH -- requirements
Module: div_datapath

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port Reset, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have the port Run, input, 1 bit: operation request, held high for the whole operation; the same Run that drives the iteration controller.
REQ-004 The block SHALL have the port W_ctrl, input, 1 bit: write enable from the controller; when low, the state and registers hold (stall).
REQ-005 The block SHALL have the port Dividend, input, 32 bits: the numerator, sampled at load.
REQ-006 The block SHALL have the port Divisor, input, 32 bits: the denominator, sampled at load.
REQ-007 The block SHALL have the port Quotient, output, 32 bits: the registered result.
REQ-008 The block SHALL have the port Remainder, output, 32 bits: the registered result.
REQ-009 The block SHALL have the port Done, output, 1 bit: result valid; held high until Run falls.
REQ-010 The block SHALL have the port DivZero, output, 1 bit: the last completed operation had Divisor==0.

Function
REQ-011 The FSM SHALL have exactly three states, IDLE, ITER and DONE, and SHALL hold state on any edge with W_ctrl=0.
REQ-012 In IDLE with Run=1 and W_ctrl=1, the block SHALL load on that edge: the 33-bit partial remainder is cleared, Dividend goes to the shift register, Divisor is captured, the 6-bit step counter is cleared, Done is cleared and DivZero is cleared.
REQ-013 At load, if Divisor==0 the FSM SHALL go to DONE, otherwise to ITER.
REQ-014 Each enabled ITER edge SHALL perform one restoring step:
- shift the remainder left by 1 and bring in the dividend MSB;
- if remainder >= divisor (33-bit unsigned compare), subtract the divisor and shift 1 into the quotient; else shift 0;
- increment the step counter.
REQ-015 After the 32nd step edge, the FSM SHALL go to DONE, and that same edge SHALL write Quotient and Remainder and set Done=1.
REQ-016 Latency SHALL be 33 enabled edges, from the first edge sampling Run=1 to Done=1, with no stalls.
REQ-017 A divide by zero SHALL give Quotient=32'hFFFFFFFF, Remainder=Dividend and DivZero=1, with Done=1 on the edge after load (2 edges total).
REQ-018 In DONE with Run=1, all outputs SHALL hold; a new operation SHALL require Run=0 for at least one edge.
REQ-019 Run=0 in any state SHALL return the FSM to IDLE on the next edge and clear Done; Quotient, Remainder and DivZero SHALL keep their last completed values.
REQ-020 Run falling mid-ITER SHALL abort: no output is updated and the next Run=1 restarts with fresh operands.
REQ-021 Run=0 SHALL override W_ctrl=0, so that an abort occurs even while stalled.
REQ-022 The step counter SHALL never wrap: the transition to DONE is taken at count 31.

Reset
REQ-023 Reset=0 SHALL immediately force state IDLE and Quotient=0, Remainder=0, Done=0 and DivZero=0, and SHALL clear all internal registers.
REQ-024 Reset asserted mid-ITER SHALL discard the operation; after release, the block SHALL wait in IDLE for Run.
REQ-025 Release of Reset SHALL be synchronous to clk by the system; the block SHALL add no internal synchronizer.

Configuration
REQ-026 With DIV_SIGNED_EN defined, the block SHALL treat operands as two's complement:
- magnitudes are taken at load;
- Quotient is negated if the operand signs differ;
- Remainder takes the sign of Dividend;
- a divide by zero gives Quotient=32'hFFFFFFFF and Remainder=Dividend, unchanged;
- latency is unchanged: the sign fix-up is applied combinationally at the output write.
REQ-027 With DIV_SIGNED_EN undefined, all arithmetic SHALL be unsigned and no sign logic SHALL be present.

Verification
REQ-028 The bench SHALL cover: Dividend=100, Divisor=7, W_ctrl=1, Run held -> on edge 33, Quotient=14, Remainder=2, Done=1, DivZero=0.
REQ-029 The bench SHALL cover: Dividend=32'hFFFFFFFF, Divisor=1 (unsigned) -> Quotient=32'hFFFFFFFF, Remainder=0, Done on edge 33.
REQ-030 The bench SHALL cover: Dividend=55, Divisor=0 -> on edge 2, Done=1, DivZero=1, Quotient=32'hFFFFFFFF, Remainder=55.
REQ-031 The bench SHALL cover: 100/7 with W_ctrl=0 for 5 edges mid-ITER -> Done on edge 38 with the same results.
REQ-032 The bench SHALL cover: Run dropped at edge 10, then 9/4 started -> outputs unchanged at the abort, then Quotient=2, Remainder=1.
REQ-033 The bench SHALL cover: with DIV_SIGNED_EN, Dividend=-7, Divisor=2 -> Quotient=-3, Remainder=-1; and Reset=0 at edge 20 of any operation -> all outputs 0 immediately.
